// File: rtl/case_6_acc_12s_16s_pkg.sv
// Shared types and default sizes for the case_6 product accumulator.
// Holds the frame FSM state enum, the 5-bit length type and the
// default product/accumulator/frame-length constants.
package case_6_acc_pkg;

   localparam int PROD_W_DEF  = 12;
   localparam int ACC_W_DEF   = 16;
   localparam int LEN_MAX_DEF = 16;

   typedef logic [4:0] len_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/case_6_acc_12s_16s_if.sv
// Frame control + product stream bundle for the case_6 accumulator.
// Ports: ap_start/ap_done/ap_idle/ap_ready control, len, prod_din/prod_vld/
// prod_ack product handshake, acc_out/acc_out_ap_vld result.
interface case_6_acc_12s_16s_if
   import case_6_acc_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
);

   logic                     ap_start;
   logic                     ap_done;
   logic                     ap_idle;
   logic                     ap_ready;
   len_t                     len;
   logic signed [PROD_W-1:0] prod_din;
   logic                     prod_vld;
   logic                     prod_ack;
   logic signed [ACC_W-1:0]  acc_out;
   logic                     acc_out_ap_vld;

   // Accumulator side
   modport slave (
      input  ap_start, len, prod_din, prod_vld,
      output ap_done, ap_idle, ap_ready, prod_ack, acc_out, acc_out_ap_vld
   );

   // Parent / producer side
   modport master (
      output ap_start, len, prod_din, prod_vld,
      input  ap_done, ap_idle, ap_ready, prod_ack, acc_out, acc_out_ap_vld
   );

endinterface

// File: rtl/case_6_acc_12s_16s.sv
// Sums a frame of signed products into a signed accumulator, start/done control.
// Latency: len transfers after start, ap_done one cycle after the last transfer.
// Backpressure: prod_ack is a pure state decode (high in ACC); prod_vld low stalls.
// Ports: ap_clk, ap_rst_n (async active-low), bus (slave modport of the frame bundle).
module case_6_acc_12s_16s
   import case_6_acc_pkg::*;
#(
   parameter int LEN_MAX = LEN_MAX_DEF,
   parameter int PROD_W  = PROD_W_DEF,
   parameter int ACC_W   = ACC_W_DEF
)(
   input  logic                ap_clk,
   input  logic                ap_rst_n,
   case_6_acc_12s_16s_if.slave bus
);

   localparam int CNT_W = $clog2(LEN_MAX) + 1;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [CNT_W-1:0]        len_q, len_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] out_q, out_d;

   logic [CNT_W-1:0]        len_clamped;
   logic [CNT_W-1:0]        cnt_inc;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] acc_sum;

   // Lengths above LEN_MAX are treated as a full frame.
   always_comb begin
      if (int'(bus.len) > LEN_MAX) len_clamped = CNT_W'(LEN_MAX);
      else                         len_clamped = CNT_W'(bus.len);
   end

   assign prod_ext = {{(ACC_W-PROD_W){bus.prod_din[PROD_W-1]}}, bus.prod_din};
   assign acc_sum  = acc_q + prod_ext;
   assign cnt_inc  = cnt_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      acc_d   = acc_q;
      out_d   = out_q;
      case (state_q)
         IDLE: begin
            if (bus.ap_start) begin
               len_d = len_clamped;
               cnt_d = '0;
               acc_d = '0;
               if (len_clamped != '0) begin
                  state_d = ACC;
               end else begin
                  // Empty frame: result is zero and reported next cycle.
                  state_d = DONE;
                  out_d   = '0;
               end
            end
         end
         ACC: begin
            if (bus.prod_vld) begin
               acc_d = acc_sum;
               cnt_d = cnt_inc;
               if (cnt_inc == len_q) begin
                  state_d = DONE;
                  out_d   = acc_sum;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         acc_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
      end
   end

   // All handshake outputs decode the registered state only.
   assign bus.ap_idle        = (state_q == IDLE);
   assign bus.prod_ack       = (state_q == ACC);
   assign bus.ap_done        = (state_q == DONE);
   assign bus.ap_ready       = (state_q == DONE);
   assign bus.acc_out_ap_vld = (state_q == DONE);
   assign bus.acc_out        = out_q;

endmodule

// File: tb/tb_case_6_acc_12s_16s.sv
module tb_case_6_acc_12s_16s;

   logic ap_clk;
   logic ap_rst_n;

   case_6_acc_12s_16s_if bus ();

   case_6_acc_12s_16s dut (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .bus      (bus)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int l;
      int n;
      int vals[16];
      int s;        // stall inserted before this product index
      int c;        // stall length in cycles
      int exp_sum;
      int exp_done; // cycle of ap_done, start sampled at edge 0
   } vec_t;

   vec_t tbl[4];

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int clamp_len(input int l);
      return (l > 16) ? 16 : l;
   endfunction

   // Runs one frame from IDLE; returns with the DUT back in IDLE.
   task automatic run_frame(input string name, input int l, input int n, input int vals[16],
                            input int s, input int c, input int exp_sum, input int exp_done);
      int k, idx, stall, xfers;
      bit got_done, ack_seen;
      check({name, "_idle_before"}, int'(bus.ap_idle), 1);
      bus.ap_start = 1'b1;
      bus.len      = 5'(l);
      bus.prod_vld = 1'b0;
      @(posedge ap_clk); #1;
      bus.ap_start = 1'b0;
      k = 1; idx = 0; stall = c; xfers = 0; got_done = 0; ack_seen = 0;
      while (!got_done && k < 200) begin
         if (bus.ap_done) begin
            got_done = 1;
         end else begin
            if (bus.prod_ack) ack_seen = 1;
            if (idx == s && stall > 0) begin
               bus.prod_vld = 1'b0;
               stall--;
            end else if (idx < n) begin
               bus.prod_vld = 1'b1;
               bus.prod_din = vals[idx][11:0];
            end else begin
               bus.prod_vld = 1'b0;
            end
            if (bus.prod_vld && bus.prod_ack) begin
               idx++;
               xfers++;
            end
            @(posedge ap_clk); #1;
            k++;
         end
      end
      bus.prod_vld = 1'b0;
      check({name, "_done_seen"}, int'(got_done), 1);
      check({name, "_done_cycle"}, k, exp_done);
      check({name, "_acc_out"}, int'(bus.acc_out), exp_sum);
      check({name, "_ready"}, int'(bus.ap_ready), 1);
      check({name, "_ap_vld"}, int'(bus.acc_out_ap_vld), 1);
      check({name, "_xfers"}, xfers, clamp_len(l));
      check({name, "_ack_seen"}, int'(ack_seen), int'(clamp_len(l) > 0));
      @(posedge ap_clk); #1;
      check({name, "_done_pulse"}, int'(bus.ap_done), 0);
      check({name, "_idle_after"}, int'(bus.ap_idle), 1);
      check({name, "_acc_hold"}, int'(bus.acc_out), exp_sum);
   endtask

   initial begin
      int k, xfers, cl, sum;
      bit got, done_seen;
      int rv[16];

      // Full positive frame
      tbl[0].l = 16; tbl[0].n = 16; tbl[0].s = 99; tbl[0].c = 0;
      for (int i = 0; i < 16; i++) tbl[0].vals[i] = 1024;
      tbl[0].exp_sum = 16384; tbl[0].exp_done = 17;
      // Mixed sign, two stall cycles before the 3rd product
      tbl[1].l = 4; tbl[1].n = 4; tbl[1].s = 2; tbl[1].c = 2;
      for (int i = 0; i < 16; i++) tbl[1].vals[i] = 0;
      tbl[1].vals[0] = -1016; tbl[1].vals[1] = 7; tbl[1].vals[2] = -8; tbl[1].vals[3] = 1000;
      tbl[1].exp_sum = -17; tbl[1].exp_done = 7;
      // Zero length
      tbl[2].l = 0; tbl[2].n = 0; tbl[2].s = 99; tbl[2].c = 0;
      for (int i = 0; i < 16; i++) tbl[2].vals[i] = 0;
      tbl[2].exp_sum = 0; tbl[2].exp_done = 1;
      // Single most-negative product, stall before the first transfer
      tbl[3].l = 1; tbl[3].n = 1; tbl[3].s = 0; tbl[3].c = 3;
      for (int i = 0; i < 16; i++) tbl[3].vals[i] = 0;
      tbl[3].vals[0] = -1016;
      tbl[3].exp_sum = -1016; tbl[3].exp_done = 5;

      ap_rst_n     = 1'b0;
      bus.ap_start = 1'b0;
      bus.len      = '0;
      bus.prod_din = '0;
      bus.prod_vld = 1'b0;
      #12;
      check("rst_idle",   int'(bus.ap_idle), 1);
      check("rst_done",   int'(bus.ap_done), 0);
      check("rst_ready",  int'(bus.ap_ready), 0);
      check("rst_ack",    int'(bus.prod_ack), 0);
      check("rst_acc",    int'(bus.acc_out), 0);
      check("rst_ap_vld", int'(bus.acc_out_ap_vld), 0);
      @(posedge ap_clk); #1;
      ap_rst_n = 1'b1;

      for (int t = 0; t < 4; t++)
         run_frame($sformatf("tbl%0d", t), tbl[t].l, tbl[t].n, tbl[t].vals,
                   tbl[t].s, tbl[t].c, tbl[t].exp_sum, tbl[t].exp_done);

      // Reset in the middle of a frame
      bus.ap_start = 1'b1; bus.len = 5'd8;
      @(posedge ap_clk); #1;
      bus.ap_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.prod_vld = 1'b1; bus.prod_din = 12'sd100;
         @(posedge ap_clk); #1;
      end
      check("midrst_ack_before", int'(bus.prod_ack), 1);
      ap_rst_n = 1'b0; bus.prod_vld = 1'b0;
      #1;
      check("midrst_idle",   int'(bus.ap_idle), 1);
      check("midrst_ack",    int'(bus.prod_ack), 0);
      check("midrst_done",   int'(bus.ap_done), 0);
      check("midrst_ready",  int'(bus.ap_ready), 0);
      check("midrst_acc",    int'(bus.acc_out), 0);
      check("midrst_ap_vld", int'(bus.acc_out_ap_vld), 0);
      done_seen = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge ap_clk); #1;
         if (bus.ap_done) done_seen = 1;
      end
      ap_rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge ap_clk); #1;
         if (bus.ap_done) done_seen = 1;
      end
      check("midrst_no_done", int'(done_seen), 0);
      for (int i = 0; i < 16; i++) rv[i] = 0;
      rv[0] = 5; rv[1] = -3;
      run_frame("post_rst", 2, 2, rv, 99, 0, 2, 3);

      // Clamp to 16 with start held high: back-to-back restart
      bus.ap_start = 1'b1; bus.len = 5'd31; bus.prod_vld = 1'b1; bus.prod_din = 12'sd1;
      @(posedge ap_clk); #1;
      k = 1; xfers = 0; got = 0;
      while (!got && k < 100) begin
         if (bus.ap_done) got = 1;
         else begin
            if (bus.prod_ack) xfers++;
            @(posedge ap_clk); #1;
            k++;
         end
      end
      check("clamp_done_seen",  int'(got), 1);
      check("clamp_done_cycle", k, 17);
      check("clamp_acc",        int'(bus.acc_out), 16);
      check("clamp_xfers",      xfers, 16);
      check("clamp_ack_done",   int'(bus.prod_ack), 0);
      @(posedge ap_clk); #1;
      check("clamp_gap_idle",   int'(bus.ap_idle), 1);
      check("clamp_gap_ack",    int'(bus.prod_ack), 0);
      @(posedge ap_clk); #1;
      check("clamp_restart_ack", int'(bus.prod_ack), 1);
      bus.ap_start = 1'b0;
      k = 0; xfers = 0; got = 0;
      while (!got && k < 100) begin
         if (bus.ap_done) got = 1;
         else begin
            if (bus.prod_ack) xfers++;
            @(posedge ap_clk); #1;
            k++;
         end
      end
      bus.prod_vld = 1'b0;
      check("clamp2_done_seen", int'(got), 1);
      check("clamp2_acc",       int'(bus.acc_out), 16);
      check("clamp2_xfers",     xfers, 16);
      @(posedge ap_clk); #1;

      // Randomized frames against a plain-arithmetic reference
      for (int t = 0; t < 12; t++) begin
         int l, s, c, edone;
         l = int'($urandom_range(0, 22));
         s = int'($urandom_range(0, 15));
         c = int'($urandom_range(0, 3));
         for (int i = 0; i < 16; i++) rv[i] = int'($urandom_range(0, 2040)) - 1016;
         cl  = clamp_len(l);
         sum = 0;
         for (int i = 0; i < cl; i++) sum += rv[i];
         edone = (cl == 0) ? 1 : 1 + cl + ((s < cl) ? c : 0);
         run_frame($sformatf("rnd%0d", t), l, cl, rv, s, c, sum, edone);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
